// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write-to-read
// bypass and a per-register pending-write scoreboard.
module regfile_mp #(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned NREGS   = 32,
   parameter int unsigned NRPORTS = 2,
   parameter int unsigned NWPORTS = 2,
   parameter bit          BYPASS  = 1'b1,
   parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(32'h0000_1000),
   localparam int unsigned AW = $clog2(NREGS),
   localparam int unsigned CW = $clog2(NREGS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NRPORTS*AW-1:0]     rd_addr_i,
   output logic [NRPORTS*DWIDTH-1:0] rd_data_o,
   output logic [NRPORTS-1:0]        rd_busy_o,
   input  logic [NWPORTS-1:0]        wr_en_i,
   input  logic [NWPORTS*AW-1:0]     wr_addr_i,
   input  logic [NWPORTS*DWIDTH-1:0] wr_data_i,
   input  logic                      issue_en_i,
   input  logic [AW-1:0]             issue_rd_i,
   output logic [CW-1:0]             pending_cnt_o
);

   logic [DWIDTH-1:0] regs_q [NREGS];
   logic [DWIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pend_q, pend_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   // x0 and out-of-range addresses never store, track or return anything
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < (AW+1)'(NREGS));
   endfunction

   // next storage and pending state; later write ports override earlier
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      for (int w = 0; w < NWPORTS; w++) begin
         if (wr_en_i[w] && addr_ok(wr_addr_i[w*AW +: AW])) begin
            regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*DWIDTH +: DWIDTH];
            pend_d[wr_addr_i[w*AW +: AW]] = 1'b0;
         end
      end
      if (issue_en_i && addr_ok(issue_rd_i)) begin
         pend_d[issue_rd_i] = 1'b1;
      end
   end

   // pending counter follows the net set/clear transitions
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NREGS; i++) begin
         if (pend_d[i] && !pend_q[i]) begin
            cnt_d = cnt_d + CW'(1);
         end else if (!pend_d[i] && pend_q[i]) begin
            cnt_d = cnt_d - CW'(1);
         end
      end
   end

   // state registers with synchronous reset; x2 holds the stack pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == 2) ? SP_INIT : '0;
         end
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pending_cnt_o = cnt_q;

   for (genvar k = 0; k < NRPORTS; k++) begin : g_rd
      logic [AW-1:0]     a;
      logic [DWIDTH-1:0] d;
      logic              b;

      assign a = rd_addr_i[k*AW +: AW];

      // read mux: stored value, overridden by highest matching writeback
      always_comb begin
         d = '0;
         b = 1'b0;
         if (addr_ok(a)) begin
            d = regs_q[a];
            b = pend_q[a];
            if (BYPASS) begin
               for (int w = 0; w < NWPORTS; w++) begin
                  if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == a)) begin
                     d = wr_data_i[w*DWIDTH +: DWIDTH];
                     b = 1'b0;
                  end
               end
            end
         end
      end

      assign rd_data_o[k*DWIDTH +: DWIDTH] = d;
      assign rd_busy_o[k] = b;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, bypass and
// non-bypass instances driven from one stimulus stream.
module tb_regfile_mp;

   localparam logic [31:0] SP = 32'h0000_3FF0;

   typedef struct {
      int          id;
      logic [31:0] d1 [2];
      logic        b1 [2];
      logic [31:0] d0 [2];
      logic        b0 [2];
      logic [5:0]  cnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [63:0] rd_data1, rd_data0;
   logic [1:0]  rd_busy1, rd_busy0;
   logic [5:0]  cnt1, cnt0;

   regfile_mp #(.BYPASS(1'b1), .SP_INIT(SP)) dut1 (
      .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data1),
      .rd_busy_o(rd_busy1), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .issue_en_i(issue_en), .issue_rd_i(issue_rd),
      .pending_cnt_o(cnt1));

   regfile_mp #(.BYPASS(1'b0), .SP_INIT(SP)) dut0 (
      .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0),
      .rd_busy_o(rd_busy0), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .issue_en_i(issue_en), .issue_rd_i(issue_rd),
      .pending_cnt_o(cnt0));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model: architectural state
   logic [31:0] mem [32];
   bit          pend [32];
   exp_t        q [$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_cyc = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mem[i] = 32'h0;
         pend[i] = 1'b0;
      end
      mem[2] = SP;
   endtask

   function automatic int popcnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(pend[i]);
      return c;
   endfunction

   task automatic exp_rd(input bit byp, input logic [4:0] a,
                         input bit [1:0] we, input logic [4:0] wa [2],
                         input logic [31:0] wd [2],
                         output logic [31:0] d, output logic b);
      d = 32'h0;
      b = 1'b0;
      if (a != 0) begin
         d = mem[a];
         b = pend[a];
         if (byp) begin
            for (int w = 1; w >= 0; w--) begin
               if (we[w] && wa[w] == a) begin
                  d = wd[w];
                  b = 1'b0;
                  break;
               end
            end
         end
      end
   endtask

   // one cycle: drive, record expected outputs, then advance the model
   task automatic cyc(input bit r, input bit [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input bit ie, input logic [4:0] ir,
                      input logic [4:0] ra0, input logic [4:0] ra1);
      exp_t e;
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic [4:0]  ra [2];
      @(posedge clk);
      #1;
      wa[0] = wa0; wa[1] = wa1;
      wd[0] = wd0; wd[1] = wd1;
      ra[0] = ra0; ra[1] = ra1;
      rst      = r;
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      issue_en = ie;
      issue_rd = ir;
      rd_addr  = {ra1, ra0};
      e.id = n_cyc++;
      for (int k = 0; k < 2; k++) begin
         exp_rd(1'b1, ra[k], we, wa, wd, e.d1[k], e.b1[k]);
         exp_rd(1'b0, ra[k], we, wa, wd, e.d0[k], e.b0[k]);
      end
      e.cnt = 6'(popcnt());
      q.push_back(e);
      if (r) begin
         model_reset();
      end else begin
         for (int w = 0; w < 2; w++) begin
            if (we[w] && wa[w] != 0) begin
               mem[wa[w]] = wd[w];
               pend[wa[w]] = 1'b0;
            end
         end
         if (ie && ir != 0) pend[ir] = 1'b1;
      end
   endtask

   task automatic check(input string nm, input int id,
                        input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, id, act, exp);
      end
   endtask

   // monitor: compare presented outputs against the queued expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         for (int k = 0; k < 2; k++) begin
            check($sformatf("byp_data%0d", k), e.id,
                  rd_data1[k*32 +: 32], e.d1[k]);
            check($sformatf("byp_busy%0d", k), e.id,
                  32'(rd_busy1[k]), 32'(e.b1[k]));
            check($sformatf("nob_data%0d", k), e.id,
                  rd_data0[k*32 +: 32], e.d0[k]);
            check($sformatf("nob_busy%0d", k), e.id,
                  32'(rd_busy0[k]), 32'(e.b0[k]));
         end
         check("byp_cnt", e.id, 32'(cnt1), 32'(e.cnt));
         check("nob_cnt", e.id, 32'(cnt0), 32'(e.cnt));
      end
   end

   initial begin
      rst = 1'b1;
      wr_en = '0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_rd = '0; rd_addr = '0;
      model_reset();
      @(posedge clk);
      #1;
      // reset state
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 2, 1);
      // same-address write conflict: port 1 wins
      cyc(0, 2'b11, 5, 32'hDEADBEEF, 5, 32'h12345678, 0, 0, 5, 0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 2);
      // x0 is hardwired
      cyc(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 5);
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      // issue, then writeback with bypass
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 7, 7, 0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
      cyc(0, 2'b01, 7, 32'hA5, 0, 0, 0, 0, 7, 7);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
      // issue and writeback to the same register
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0);
      cyc(0, 2'b10, 0, 0, 9, 32'h99, 1, 9, 9, 0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3);
      // plain write: old value same cycle without bypass
      cyc(0, 2'b01, 3, 32'h3333, 0, 0, 0, 0, 3, 9);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 9);
      // pending state and writes discarded by reset
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 0);
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 6, 4, 6);
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 8, 6, 8);
      cyc(1, 2'b11, 10, 32'hBAD0, 2, 32'hBAD2, 1, 11, 4, 8);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 2, 10);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 9);
      // randomized traffic over a narrow address window to force hits
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 79) == 0),
             2'($urandom),
             5'($urandom_range(0, 11)), $urandom,
             5'($urandom_range(0, 11)), $urandom,
             ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 11)),
             5'($urandom_range(0, 12)), 5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
